// File: rtl/zeroriscy_trap_sequencer.sv
// Trap entry/exit sequencer for the zero-riscy core.
// It picks between a synchronous exception, an external interrupt and MRET.
// It waits for outstanding load/store traffic to finish, then pulses the CSR
// save or restore strobes for one cycle and redirects fetch.
// ID stays halted until the first post-trap instruction arrives from IF.
// All outputs are registered: each one is computed from the state being entered.
module zeroriscy_trap_sequencer #(
    parameter int N_IRQ    = 16,
    parameter bit SYNC_IRQ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             m_irq_enable_i,
    input  logic             instr_boundary_i,
    input  logic             exc_req_i,
    input  logic [4:0]       exc_cause_i,
    input  logic             mret_i,
    input  logic             lsu_busy_i,
    input  logic             if_valid_i,
    output logic             csr_save_cause_o,
    output logic             csr_save_if_o,
    output logic             csr_save_id_o,
    output logic [5:0]       csr_cause_o,
    output logic             csr_restore_mret_o,
    output logic             pc_set_o,
    output logic             pc_mux_o,
    output logic [4:0]       exc_vec_o,
    output logic             halt_id_o,
    output logic             busy_o,
    output logic [15:0]      trap_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SAVE,
        RESTORE,
        REFETCH
    } state_t;

    state_t           state_reg;
    logic [N_IRQ-1:0] irq_q;
    logic [5:0]       cause_reg;
    logic             src_id_reg;
    logic             kind_mret_reg;
    logic [15:0]      cnt_reg;
    logic [4:0]       irq_idx;
    logic             irq_pend;

    // The irq lines are asynchronous to clk.
    // With SYNC_IRQ=1 they pass through two flops before use.
    generate
        if (SYNC_IRQ) begin : g_sync2
            logic [N_IRQ-1:0] meta_reg;
            logic [N_IRQ-1:0] sync_reg;
            // Two-stage synchronizer on the interrupt lines
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg <= '0;
                    sync_reg <= '0;
                end else begin
                    meta_reg <= irq_i;
                    sync_reg <= meta_reg;
                end
            end
            assign irq_q = sync_reg;
        end else begin : g_sync1
            logic [N_IRQ-1:0] samp_reg;
            // Single sampling register on the interrupt lines
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    samp_reg <= '0;
                end else begin
                    samp_reg <= irq_i;
                end
            end
            assign irq_q = samp_reg;
        end
    endgenerate

    // Find the lowest-index pending line.
    // The scan runs downward, so the last hit is the lowest index.
    always_comb begin
        irq_idx = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq_q[i]) begin
                irq_idx = 5'(i);
            end
        end
    end

    assign irq_pend   = (|irq_q) & m_irq_enable_i;
    assign trap_cnt_o = cnt_reg;

    // Sequencer FSM.
    // Strobes default low every cycle, so a strobe lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            cause_reg          <= '0;
            src_id_reg         <= 1'b0;
            kind_mret_reg      <= 1'b0;
            cnt_reg            <= '0;
            csr_save_cause_o   <= 1'b0;
            csr_save_if_o      <= 1'b0;
            csr_save_id_o      <= 1'b0;
            csr_cause_o        <= '0;
            csr_restore_mret_o <= 1'b0;
            pc_set_o           <= 1'b0;
            pc_mux_o           <= 1'b0;
            exc_vec_o          <= '0;
            halt_id_o          <= 1'b0;
            busy_o             <= 1'b0;
        end else begin
            csr_save_cause_o   <= 1'b0;
            csr_save_if_o      <= 1'b0;
            csr_save_id_o      <= 1'b0;
            csr_cause_o        <= '0;
            csr_restore_mret_o <= 1'b0;
            pc_set_o           <= 1'b0;
            pc_mux_o           <= 1'b0;
            exc_vec_o          <= '0;
            case (state_reg)
                IDLE: begin
                    if (exc_req_i) begin
                        cause_reg     <= {1'b0, exc_cause_i};
                        src_id_reg    <= 1'b1;
                        kind_mret_reg <= 1'b0;
                        state_reg     <= DRAIN;
                        halt_id_o     <= 1'b1;
                        busy_o        <= 1'b1;
                    end else if (irq_pend && instr_boundary_i) begin
                        cause_reg     <= {1'b1, irq_idx};
                        src_id_reg    <= 1'b0;
                        kind_mret_reg <= 1'b0;
                        state_reg     <= DRAIN;
                        halt_id_o     <= 1'b1;
                        busy_o        <= 1'b1;
                    end else if (mret_i) begin
                        kind_mret_reg <= 1'b1;
                        state_reg     <= DRAIN;
                        halt_id_o     <= 1'b1;
                        busy_o        <= 1'b1;
                    end else begin
                        halt_id_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!lsu_busy_i) begin
                        pc_set_o <= 1'b1;
                        if (kind_mret_reg) begin
                            state_reg          <= RESTORE;
                            csr_restore_mret_o <= 1'b1;
                            pc_mux_o           <= 1'b1;
                        end else begin
                            state_reg        <= SAVE;
                            csr_save_cause_o <= 1'b1;
                            csr_save_id_o    <= src_id_reg;
                            csr_save_if_o    <= ~src_id_reg;
                            csr_cause_o      <= cause_reg;
                            exc_vec_o        <= cause_reg[4:0];
                            if (cnt_reg != 16'hFFFF) begin
                                cnt_reg <= cnt_reg + 16'd1;
                            end
                        end
                    end
                end
                SAVE, RESTORE: begin
                    state_reg <= REFETCH;
                end
                REFETCH: begin
                    if (if_valid_i) begin
                        state_reg <= IDLE;
                        halt_id_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    halt_id_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule
